// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the data-side memory controller.
// Holds the address map (also used by the fetch block's conflict check),
// the controller state encoding, the access target encoding and the
// address decoder.
package data_memory_ctrl_pkg;

  localparam logic [15:0] RAM1_UPPER   = 16'h8000;
  localparam logic [15:0] COM1_DATA    = 16'hBF00;
  localparam logic [15:0] COM1_COMMAND = 16'hBF01;
  localparam logic [15:0] COM2_DATA    = 16'hBF02;
  localparam logic [15:0] COM2_COMMAND = 16'hBF03;

  typedef enum logic [3:0] {
    IDLE, RD1, RD2, WR1, WR2, WR3, URD, UWR, DONE
  } state_e;

  typedef enum logic [2:0] {
    TGT_R1, TGT_R2, TGT_UDATA, TGT_USTAT, TGT_NULL
  } target_e;

  function automatic target_e decode_addr(input logic [15:0] addr);
    if (addr < RAM1_UPPER)                             return TGT_R1;
    else if (addr == COM1_DATA)                        return TGT_UDATA;
    else if (addr == COM1_COMMAND)                     return TGT_USTAT;
    else if (addr == COM2_DATA || addr == COM2_COMMAND) return TGT_NULL;
    else                                               return TGT_R2;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Pipeline-side request/response bundle of the data memory controller.
//   master : MEM stage (drives MemRead/MemWrite/DM_Address/WriteData)
//   slave  : controller (returns ReadData and MemStall)
interface data_memory_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] DM_Address;
  logic [15:0] WriteData;
  logic [15:0] ReadData;
  logic        MemStall;

  modport master (
    output MemRead, MemWrite, DM_Address, WriteData,
    input  ReadData, MemStall
  );

  modport slave (
    input  MemRead, MemWrite, DM_Address, WriteData,
    output ReadData, MemStall
  );
endinterface

// File: rtl/data_memory_ctrl_sram_port.sv
// Strobe/address/data-drive sequencer for one asynchronous SRAM.
// Follows the controller's next state while selected, so every strobe is a
// registered output that changes on the same edge as the controller state.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   sel               this SRAM is the target of the current/next access
//   state_d           controller next state
//   addr, wdata       request address and store data (captured at start)
//   ram_addr          SRAM address
//   ram_oe_n/we_n/en_n active-low strobes
//   dq_oe, dq_o       data bus drive enable and value (tri-state at top)
module data_memory_ctrl_sram_port
  import data_memory_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  state_e      state_d,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [17:0] ram_addr,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        ram_en_n,
  output logic        dq_oe,
  output logic [15:0] dq_o
);

  logic [17:0] addr_d, addr_q;
  logic [15:0] wdata_d, wdata_q;
  logic        en_n_d, en_n_q, oe_n_d, oe_n_q, we_n_d, we_n_q;
  logic        drive_d, drive_q;

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    en_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    drive_d = 1'b0;
    if (sel) begin
      case (state_d)
        RD1, RD2: begin en_n_d = 1'b0; oe_n_d = 1'b0; end
        WR1, WR3: begin en_n_d = 1'b0; drive_d = 1'b1; end
        WR2:      begin en_n_d = 1'b0; we_n_d = 1'b0; drive_d = 1'b1; end
        default:  ;
      endcase
      // RD1/WR1 are only entered from IDLE: latch the request there so a
      // pipeline flush mid-access cannot disturb address or data.
      if (state_d == RD1 || state_d == WR1) begin
        addr_d  = {2'b00, addr};
        wdata_d = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      en_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      en_n_q  <= en_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drive_q <= drive_d;
    end
  end

  assign ram_addr = addr_q;
  assign ram_oe_n = oe_n_q;
  assign ram_we_n = we_n_q;
  assign ram_en_n = en_n_q;
  assign dq_oe    = drive_q;
  assign dq_o     = wdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory controller: decodes each load/store to RAM1, the
// COM1 UART data/status registers, the reserved COM2 ports or RAM2, runs
// the access sequence and holds the pipeline with MemStall until DONE.
// Ports:
//   clk, rst            clock, async active-low reset
//   mem_if (slave)      MemRead/MemWrite/DM_Address/WriteData in,
//                       ReadData/MemStall out
//   Ram1*/Ram2*         SRAM buses and active-low strobes
//   rdn, wrn            UART strobes, active-low
//   data_ready/tbre/tsre UART status inputs
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  data_memory_ctrl_if.slave   mem_if,
  inout  wire  [15:0]         Ram1Data,
  output logic [17:0]         Ram1Addr,
  output logic                Ram1OE,
  output logic                Ram1WE,
  output logic                Ram1EN,
  inout  wire  [15:0]         Ram2Data,
  output logic [17:0]         Ram2Addr,
  output logic                Ram2OE,
  output logic                Ram2WE,
  output logic                Ram2EN,
  output logic                rdn,
  output logic                wrn,
  input  logic                data_ready,
  input  logic                tbre,
  input  logic                tsre
);

  state_e      state_q, state_d;
  target_e     tgt_q, tgt_d;
  logic [15:0] read_data_q, read_data_d;
  logic [15:0] uart_wdata_q, uart_wdata_d;
  logic        rdn_q, rdn_d, wrn_q, wrn_d;
  logic        uart_drive_q, uart_drive_d;
  logic        req;
  logic        r1_oe, r2_oe;
  logic [15:0] r1_dq, r2_dq;

  assign req = mem_if.MemRead | mem_if.MemWrite;

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    read_data_d  = read_data_q;
    uart_wdata_d = uart_wdata_q;
    case (state_q)
      IDLE: if (req) begin
        tgt_d        = decode_addr(mem_if.DM_Address);
        uart_wdata_d = mem_if.WriteData;
        case (tgt_d)
          TGT_R1, TGT_R2: state_d = mem_if.MemWrite ? WR1 : RD1;
          TGT_UDATA:      state_d = mem_if.MemWrite ? UWR : URD;
          TGT_USTAT: begin
            state_d = DONE;
            if (!mem_if.MemWrite) read_data_d = {14'b0, data_ready, tbre & tsre};
          end
          default: begin
            state_d = DONE;
            if (!mem_if.MemWrite) read_data_d = '0;
          end
        endcase
      end
      RD1: state_d = RD2;
      RD2: begin
        state_d     = DONE;
        read_data_d = (tgt_q == TGT_R1) ? Ram1Data : Ram2Data;
      end
      WR1: state_d = WR2;
      WR2: state_d = WR3;
      WR3: state_d = DONE;
      URD: begin
        state_d     = DONE;
        read_data_d = Ram1Data;
      end
      UWR:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdn_d        = (state_d != URD);
    wrn_d        = (state_d != UWR);
    uart_drive_d = (state_d == UWR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tgt_q        <= TGT_NULL;
      read_data_q  <= '0;
      uart_wdata_q <= '0;
      rdn_q        <= 1'b1;
      wrn_q        <= 1'b1;
      uart_drive_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      read_data_q  <= read_data_d;
      uart_wdata_q <= uart_wdata_d;
      rdn_q        <= rdn_d;
      wrn_q        <= wrn_d;
      uart_drive_q <= uart_drive_d;
    end
  end

  // tgt_d equals tgt_q outside IDLE, so the selects stay stable for the
  // whole access; the SRAM strobes also idle whenever state_d is IDLE/DONE.
  data_memory_ctrl_sram_port u_ram1 (
    .clk      (clk),
    .rst_n    (rst),
    .sel      (tgt_d == TGT_R1),
    .state_d  (state_d),
    .addr     (mem_if.DM_Address),
    .wdata    (mem_if.WriteData),
    .ram_addr (Ram1Addr),
    .ram_oe_n (Ram1OE),
    .ram_we_n (Ram1WE),
    .ram_en_n (Ram1EN),
    .dq_oe    (r1_oe),
    .dq_o     (r1_dq)
  );

  data_memory_ctrl_sram_port u_ram2 (
    .clk      (clk),
    .rst_n    (rst),
    .sel      (tgt_d == TGT_R2),
    .state_d  (state_d),
    .addr     (mem_if.DM_Address),
    .wdata    (mem_if.WriteData),
    .ram_addr (Ram2Addr),
    .ram_oe_n (Ram2OE),
    .ram_we_n (Ram2WE),
    .ram_en_n (Ram2EN),
    .dq_oe    (r2_oe),
    .dq_o     (r2_dq)
  );

  // RAM1 and the UART share Ram1Data; their drive windows never overlap.
  assign Ram1Data = r1_oe ? r1_dq : (uart_drive_q ? uart_wdata_q : 16'hzzzz);
  assign Ram2Data = r2_oe ? r2_dq : 16'hzzzz;

  assign rdn = rdn_q;
  assign wrn = wrn_q;

  assign mem_if.ReadData = read_data_q;
  // Gated by reset so the pipeline is released while the controller is held.
  assign mem_if.MemStall = rst & req & (state_q != DONE);

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_memory_ctrl_if dif();

  wire  [15:0] Ram1Data, Ram2Data;
  logic [17:0] Ram1Addr, Ram2Addr;
  logic Ram1OE, Ram1WE, Ram1EN, Ram2OE, Ram2WE, Ram2EN, rdn, wrn;
  logic data_ready, tbre, tsre;

  data_memory_ctrl dut (
    .clk(clk), .rst(rst), .mem_if(dif),
    .Ram1Data(Ram1Data), .Ram1Addr(Ram1Addr), .Ram1OE(Ram1OE), .Ram1WE(Ram1WE), .Ram1EN(Ram1EN),
    .Ram2Data(Ram2Data), .Ram2Addr(Ram2Addr), .Ram2OE(Ram2OE), .Ram2WE(Ram2WE), .Ram2EN(Ram2EN),
    .rdn(rdn), .wrn(wrn), .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  // memory / UART / bus-probe models
  logic [15:0] mem1 [0:65535];
  logic [15:0] mem2 [0:65535];
  logic [15:0] uart_rx = 16'h005A;
  logic [15:0] probe_val = 16'h0000;
  logic        probe_en = 1'b0;

  assign Ram1Data = (!Ram1EN && !Ram1OE) ? mem1[Ram1Addr[15:0]] :
                    (!rdn ? uart_rx : (probe_en ? probe_val : 16'hzzzz));
  assign Ram2Data = (!Ram2EN && !Ram2OE) ? mem2[Ram2Addr[15:0]] :
                    (probe_en ? probe_val : 16'hzzzz);

  initial begin
    for (int i = 0; i < 65536; i++) begin mem1[i] = 16'h0000; mem2[i] = 16'h0000; end
    mem1[16'h0020] = 16'h7777;
    mem1[16'h7FFF] = 16'h7F7F;
    mem2[16'h8000] = 16'h8888;
    mem2[16'h9000] = 16'h1234;
    mem2[16'hFFFF] = 16'hCAFE;
    forever begin
      @(posedge clk);
      if (!Ram1EN && !Ram1WE) mem1[Ram1Addr[15:0]] = Ram1Data;
      if (!Ram2EN && !Ram2WE) mem2[Ram2Addr[15:0]] = Ram2Data;
    end
  end

  // strobe activity monitor
  int n_we1 = 0, n_wrn = 0, n_rdn = 0, n_en1 = 0, n_en2 = 0, n_conf = 0;
  logic [15:0] uart_tx = 16'h0000;
  always @(negedge clk) begin
    if (!Ram1WE) n_we1++;
    if (!wrn) begin n_wrn++; uart_tx = Ram1Data; end
    if (!rdn) n_rdn++;
    if (!Ram1EN) n_en1++;
    if (!Ram2EN) n_en2++;
    if (!Ram1EN && (!rdn || !wrn)) n_conf++;
  end

  int n_checks = 0, n_fail = 0;
  typedef struct packed { logic [15:0] data; int stalls; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [15:0] model_rd = 16'h0000;
  int s_we1, s_wrn, s_rdn, s_en1, s_en2, s_conf;

  task automatic snap();
    s_we1 = n_we1; s_wrn = n_wrn; s_rdn = n_rdn; s_en1 = n_en1; s_en2 = n_en2; s_conf = n_conf;
  endtask

  task automatic idle();
    dif.MemRead = 1'b0; dif.MemWrite = 1'b0;
  endtask

  // Drives one request and follows it to DONE; call at negedge+1, or with
  // b2b=1 right after the previous access returned (its DONE cycle).
  task automatic access(input bit b2b, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, output int stalls, output logic [15:0] rd);
    dif.MemRead = !wr; dif.MemWrite = wr; dif.DM_Address = a; dif.WriteData = wd;
    stalls = 0;
    if (b2b) @(negedge clk);
    #1;
    while (dif.MemStall === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk); #1;
    end
    rd = dif.ReadData;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); dif.DM_Address = '0; dif.WriteData = '0;
    data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
    repeat (2) @(negedge clk); #1;
    n_checks++; if (dif.ReadData !== 16'h0) begin n_fail++; $display("FAIL reset_readdata got %h expected 0000", dif.ReadData); end
    n_checks++; if ({Ram1OE, Ram1WE, Ram1EN, Ram2OE, Ram2WE, Ram2EN, rdn, wrn} !== 8'hFF) begin
      n_fail++; $display("FAIL reset_strobes got %b expected 11111111", {Ram1OE, Ram1WE, Ram1EN, Ram2OE, Ram2WE, Ram2EN, rdn, wrn}); end
    n_checks++; if ({Ram1Addr, Ram2Addr} !== 36'h0) begin n_fail++; $display("FAIL reset_addr got %h %h expected 0", Ram1Addr, Ram2Addr); end
    dif.MemRead = 1'b1; #1;
    n_checks++; if (dif.MemStall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b expected 0", dif.MemStall); end
    idle();
    probe_en = 1'b1; probe_val = 16'h0000; #1;
    n_checks++; if ({Ram1Data, Ram2Data} !== 32'h0) begin n_fail++; $display("FAIL reset_bus_release0 got %h %h expected 0000 0000", Ram1Data, Ram2Data); end
    probe_val = 16'hFFFF; #1;
    n_checks++; if ({Ram1Data, Ram2Data} !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_bus_releaseF got %h %h expected ffff ffff", Ram1Data, Ram2Data); end
    probe_en = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_ram1_rw();
    int st; logic [15:0] rd;
    @(negedge clk); #1; snap();
    exp_q.push_back('{data: model_rd, stalls: 4});
    access(0, 1'b1, 16'h0010, 16'hA5A5, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL r1_write_readdata got %h expected %h", rd, e.data); end
    n_checks++; if (st !== e.stalls) begin n_fail++; $display("FAIL r1_write_stalls got %0d expected %0d", st, e.stalls); end
    n_checks++; if (n_we1 - s_we1 !== 1) begin n_fail++; $display("FAIL r1_we_pulse got %0d cycles expected 1", n_we1 - s_we1); end
    n_checks++; if (mem1[16'h0010] !== 16'hA5A5) begin n_fail++; $display("FAIL r1_mem_content got %h expected a5a5", mem1[16'h0010]); end
    @(negedge clk); #1; snap();
    model_rd = 16'hA5A5; exp_q.push_back('{data: model_rd, stalls: 3});
    access(0, 1'b0, 16'h0010, 16'h0000, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL r1_read_data got %h expected %h", rd, e.data); end
    n_checks++; if (st !== e.stalls) begin n_fail++; $display("FAIL r1_read_stalls got %0d expected %0d", st, e.stalls); end
    n_checks++; if (Ram1Addr !== 18'h00010) begin n_fail++; $display("FAIL r1_addr got %h expected 00010", Ram1Addr); end
    n_checks++; if (n_en1 - s_en1 !== 2 || n_en2 - s_en2 !== 0) begin
      n_fail++; $display("FAIL r1_read_en got %0d/%0d expected 2/0", n_en1 - s_en1, n_en2 - s_en2); end
  endtask

  task automatic test_ram2();
    int st; logic [15:0] rd;
    @(negedge clk); #1; snap();
    model_rd = 16'h1234; exp_q.push_back('{data: model_rd, stalls: 3});
    access(0, 1'b0, 16'h9000, 16'h0000, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL r2_read_data got %h expected %h", rd, e.data); end
    n_checks++; if (st !== e.stalls) begin n_fail++; $display("FAIL r2_read_stalls got %0d expected %0d", st, e.stalls); end
    n_checks++; if (n_en1 - s_en1 !== 0) begin n_fail++; $display("FAIL r2_ram1_idle got %0d en cycles expected 0", n_en1 - s_en1); end
    n_checks++; if (Ram2Addr !== 18'h09000) begin n_fail++; $display("FAIL r2_addr got %h expected 09000", Ram2Addr); end
    @(negedge clk); #1; snap();
    exp_q.push_back('{data: model_rd, stalls: 4});
    access(0, 1'b1, 16'hC000, 16'h5A5A, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data || st !== e.stalls) begin n_fail++; $display("FAIL r2_write got %h/%0d expected %h/%0d", rd, st, e.data, e.stalls); end
    n_checks++; if (mem2[16'hC000] !== 16'h5A5A || n_en1 - s_en1 !== 0) begin
      n_fail++; $display("FAIL r2_write_mem got %h expected 5a5a", mem2[16'hC000]); end
    // decode boundaries
    @(negedge clk); #1; snap();
    model_rd = 16'h7F7F; exp_q.push_back('{data: model_rd, stalls: 3});
    access(0, 1'b0, 16'h7FFF, 16'h0000, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data || n_en2 - s_en2 !== 0) begin n_fail++; $display("FAIL bound_7fff got %h expected %h", rd, e.data); end
    @(negedge clk); #1; snap();
    model_rd = 16'h8888; exp_q.push_back('{data: model_rd, stalls: 3});
    access(0, 1'b0, 16'h8000, 16'h0000, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data || n_en1 - s_en1 !== 0) begin n_fail++; $display("FAIL bound_8000 got %h expected %h", rd, e.data); end
    @(negedge clk); #1;
    model_rd = 16'hCAFE; exp_q.push_back('{data: model_rd, stalls: 3});
    access(0, 1'b0, 16'hFFFF, 16'h0000, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data || st !== e.stalls) begin n_fail++; $display("FAIL bound_ffff got %h/%0d expected %h/%0d", rd, st, e.data, e.stalls); end
  endtask

  task automatic test_uart_status();
    int st; logic [15:0] rd;
    data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
    @(negedge clk); #1; snap();
    model_rd = 16'h0002; exp_q.push_back('{data: model_rd, stalls: 1});
    access(0, 1'b0, 16'hBF01, 16'h0000, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL stat_read_a got %h expected %h", rd, e.data); end
    n_checks++; if (st !== e.stalls) begin n_fail++; $display("FAIL stat_stalls got %0d expected %0d", st, e.stalls); end
    n_checks++; if (n_rdn - s_rdn !== 0 || n_wrn - s_wrn !== 0) begin
      n_fail++; $display("FAIL stat_uart_strobes got rdn %0d wrn %0d expected 0 0", n_rdn - s_rdn, n_wrn - s_wrn); end
    data_ready = 1'b0; tsre = 1'b1;
    @(negedge clk); #1;
    model_rd = 16'h0001; exp_q.push_back('{data: model_rd, stalls: 1});
    access(0, 1'b0, 16'hBF01, 16'h0000, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL stat_read_b got %h expected %h", rd, e.data); end
    @(negedge clk); #1;
    exp_q.push_back('{data: model_rd, stalls: 1});
    access(0, 1'b1, 16'hBF01, 16'hFFFF, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data || st !== e.stalls) begin n_fail++; $display("FAIL stat_write got %h/%0d expected %h/%0d", rd, st, e.data, e.stalls); end
  endtask

  task automatic test_uart_data();
    int st; logic [15:0] rd;
    @(negedge clk); #1; snap();
    exp_q.push_back('{data: model_rd, stalls: 2});
    access(0, 1'b1, 16'hBF00, 16'h0041, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data || st !== e.stalls) begin n_fail++; $display("FAIL uart_write got %h/%0d expected %h/%0d", rd, st, e.data, e.stalls); end
    n_checks++; if (n_wrn - s_wrn !== 1) begin n_fail++; $display("FAIL uart_wrn_pulse got %0d expected 1", n_wrn - s_wrn); end
    n_checks++; if (uart_tx !== 16'h0041) begin n_fail++; $display("FAIL uart_tx_data got %h expected 0041", uart_tx); end
    n_checks++; if (n_en1 - s_en1 !== 0 || n_conf - s_conf !== 0) begin
      n_fail++; $display("FAIL uart_write_ram1_en got %0d/%0d expected 0/0", n_en1 - s_en1, n_conf - s_conf); end
    @(negedge clk); #1; snap();
    model_rd = 16'h005A; exp_q.push_back('{data: model_rd, stalls: 2});
    access(0, 1'b0, 16'hBF00, 16'h0000, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data || st !== e.stalls) begin n_fail++; $display("FAIL uart_read got %h/%0d expected %h/%0d", rd, st, e.data, e.stalls); end
    n_checks++; if (n_rdn - s_rdn !== 1 || n_conf - s_conf !== 0) begin
      n_fail++; $display("FAIL uart_rdn_pulse got %0d/%0d expected 1/0", n_rdn - s_rdn, n_conf - s_conf); end
    @(negedge clk); #1; snap();
    model_rd = 16'h0000; exp_q.push_back('{data: model_rd, stalls: 1});
    access(0, 1'b0, 16'hBF02, 16'h0000, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data || st !== e.stalls) begin n_fail++; $display("FAIL com2_read got %h/%0d expected %h/%0d", rd, st, e.data, e.stalls); end
    n_checks++; if (n_en1 - s_en1 + n_en2 - s_en2 + n_rdn - s_rdn + n_wrn - s_wrn !== 0) begin
      n_fail++; $display("FAIL com2_no_strobes got %0d expected 0", n_en1 - s_en1 + n_en2 - s_en2 + n_rdn - s_rdn + n_wrn - s_wrn); end
  endtask

  task automatic test_back_to_back();
    int st [4]; logic [15:0] rd [4];
    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
    @(negedge clk); #1;
    exp_q.push_back('{data: model_rd, stalls: 4});
    access(0, 1'b1, 16'h0100, 16'hBEEF, st[0], rd[0]);
    model_rd = 16'hBEEF; exp_q.push_back('{data: model_rd, stalls: 3});
    access(1, 1'b0, 16'h0100, 16'h0000, st[1], rd[1]);
    model_rd = 16'h0001; exp_q.push_back('{data: model_rd, stalls: 1});
    access(1, 1'b0, 16'hBF01, 16'h0000, st[2], rd[2]);
    model_rd = 16'h1234; exp_q.push_back('{data: model_rd, stalls: 3});
    access(1, 1'b0, 16'h9000, 16'h0000, st[3], rd[3]);
    idle();
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (rd[i] !== e.data) begin n_fail++; $display("FAIL b2b_data[%0d] got %h expected %h", i, rd[i], e.data); end
      n_checks++; if (st[i] !== e.stalls) begin n_fail++; $display("FAIL b2b_stalls[%0d] got %0d expected %0d", i, st[i], e.stalls); end
    end
  endtask

  task automatic test_flush();
    @(negedge clk); #1; snap();
    dif.MemWrite = 1'b1; dif.DM_Address = 16'h0200; dif.WriteData = 16'h0F0F;
    @(negedge clk); #1;
    idle(); dif.WriteData = 16'h0000; dif.DM_Address = 16'h0300; #1;
    n_checks++; if (dif.MemStall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b expected 0", dif.MemStall); end
    repeat (5) @(negedge clk); #1;
    n_checks++; if (mem1[16'h0200] !== 16'h0F0F) begin n_fail++; $display("FAIL flush_completes got %h expected 0f0f", mem1[16'h0200]); end
    n_checks++; if (n_we1 - s_we1 !== 1 || n_en1 - s_en1 !== 3) begin
      n_fail++; $display("FAIL flush_single_access got we %0d en %0d expected 1 3", n_we1 - s_we1, n_en1 - s_en1); end
    n_checks++; if (dif.ReadData !== model_rd) begin n_fail++; $display("FAIL flush_readdata got %h expected %h", dif.ReadData, model_rd); end
  endtask

  task automatic test_reset_mid_write();
    int st; logic [15:0] rd;
    @(negedge clk); #1;
    dif.MemWrite = 1'b1; dif.DM_Address = 16'h0020; dif.WriteData = 16'h1111;
    repeat (2) @(negedge clk); #1;
    n_checks++; if (Ram1WE !== 1'b0) begin n_fail++; $display("FAIL mid_write_we got %b expected 0", Ram1WE); end
    rst = 1'b0; probe_en = 1'b1; probe_val = 16'h0000; #1;
    n_checks++; if ({Ram1WE, Ram1EN, dif.MemStall} !== 3'b110) begin
      n_fail++; $display("FAIL rst_abort got WE/EN/stall %b expected 110", {Ram1WE, Ram1EN, dif.MemStall}); end
    n_checks++; if (Ram1Data !== 16'h0000 || dif.ReadData !== 16'h0000) begin
      n_fail++; $display("FAIL rst_abort_bus got %h rd %h expected 0000 0000", Ram1Data, dif.ReadData); end
    probe_en = 1'b0; idle();
    @(negedge clk); rst = 1'b1; model_rd = 16'h0000;
    n_checks++; if (mem1[16'h0020] !== 16'h7777) begin n_fail++; $display("FAIL rst_mem_unchanged got %h expected 7777", mem1[16'h0020]); end
    @(negedge clk); #1;
    model_rd = 16'h7777; exp_q.push_back('{data: model_rd, stalls: 3});
    access(0, 1'b0, 16'h0020, 16'h0000, st, rd); idle();
    e = exp_q.pop_front();
    n_checks++; if (rd !== e.data || st !== e.stalls) begin n_fail++; $display("FAIL rst_readback got %h/%0d expected %h/%0d", rd, st, e.data, e.stalls); end
  endtask

  initial begin
    test_reset();
    test_ram1_rw();
    test_ram2();
    test_uart_status();
    test_uart_data();
    test_back_to_back();
    test_flush();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- MEM-stage memory controller; the data-side peer of the instruction fetch block on the shared RAM1 bus.
- Serves every data load/store: RAM1 data region (below RAM1_UPPER), COM1 UART data and status, COM2 (reserved), and RAM2 for all remaining addresses.
- When an access targets RAM1 or a COM address, the fetch block has already released the bus and issued NOP. This block then owns Ram1Data/Ram1Addr/strobes and the UART strobes.
- Asserts MemStall so the pipeline holds until the access completes.

Parameters:
- RAM1_UPPER, 16'h8000, first address not backed by RAM1 data region
- COM1_DATA, 16'hBF00, UART data register
- COM1_COMMAND, 16'hBF01, UART status register
- COM2_DATA, 16'hBF02, reserved port
- COM2_COMMAND, 16'hBF03, reserved port

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous, active-low reset
- MemRead  in  1  load request; held by pipeline while MemStall=1
- MemWrite  in  1  store request; held while MemStall=1
- DM_Address  in  16  data address
- WriteData  in  16  store data
- ReadData  out  16  load result, registered
- MemStall  out  1  pipeline hold
- Ram1Data  inout  16  shared RAM1/UART data bus
- Ram1Addr  out  18  RAM1 address
- Ram1OE / Ram1WE / Ram1EN  out  1 each  RAM1 strobes, active-low
- Ram2Data  inout  16  RAM2 data bus
- Ram2Addr  out  18  RAM2 address
- Ram2OE / Ram2WE / Ram2EN  out  1 each  RAM2 strobes, active-low
- rdn / wrn  out  1 each  UART read/write strobes, active-low
- data_ready  in  1  UART has received a byte
- tbre / tsre  in  1 each  UART transmit buffer empty / shift register empty

Behaviour:
- Reset values:
  - ReadData=0, Ram*Addr=0.
  - All OE/WE/EN=1, rdn=1, wrn=1.
  - Both data buses z.
  - State=IDLE.
- Request:
  - req = MemRead|MemWrite. MemWrite has priority if both are asserted.
  - MemStall = req && state!=DONE (combinational).
- Decode, performed in IDLE on req:
  - addr<RAM1_UPPER → R1.
  - COM1_DATA → U_DATA.
  - COM1_COMMAND → U_STAT.
  - COM2_* → NULL.
  - else → R2.
- RAM read, R1 or R2 identically, 3 cycles incl. DONE:
  - IDLE→RD1: Addr={2'b00,addr}, EN=0, OE=0, WE=1, bus z.
  - RD1→RD2: hold strobes.
  - RD2→DONE: ReadData<=bus, OE=1, EN=1.
- RAM write, 4 cycles:
  - IDLE→WR1: Addr driven, bus driven with WriteData, EN=0, WE=1.
  - WR1→WR2: WE=0.
  - WR2→WR3: WE=1, data still driven.
  - WR3→DONE: bus z, EN=1.
  - Data is stable for one full cycle on each side of the WE low pulse.
- UART data read:
  - IDLE→URD: Ram1EN=1, bus z, rdn=0.
  - URD→DONE: ReadData<=Ram1Data, rdn=1.
- UART data write:
  - IDLE→UWR: Ram1EN=1, bus driven with WriteData, wrn=0.
  - UWR→DONE: wrn=1, bus z.
- COM1_COMMAND read: IDLE→DONE. ReadData<={14'b0, data_ready, tbre&tsre}.
- COM1_COMMAND write: IDLE→DONE, no side effect.
- COM2 read: ReadData<=0. COM2 write: ignored. Both take IDLE→DONE.
- RAM1 strobes are never active in the same cycle as rdn=0 or wrn=0.
- DONE → IDLE unconditionally. MemStall=0 in DONE, so the pipeline advances on that posedge.
- Back-to-back accesses: the next request starts from IDLE one cycle later.
- ReadData holds its value until the next load completes. Stores do not change it.
- Bus rules:
  - Ram1Data is driven only in write states (WR1–WR3 for R1, UWR).
  - Ram2Data is driven only in R2 write states.
- Reset mid-operation: immediate return to IDLE. All strobes go high, buses release to z, ReadData=0. A partially pulsed WE or wrn is aborted.
- Request dropped mid-operation (pipeline flush): the current access still runs to DONE. No new access starts.

Decomposition:
- Shared package (existing define file):
  - RAM1_UPPER and the COM*_ addresses (shared with the fetch block's conflict check).
  - State encodings IDLE, RD1, RD2, WR1, WR2, WR3, URD, UWR, DONE.
- One natural sub-module: sram_port. It is the RAM read/write sequencer with its strobe and tri-state logic, instantiated twice (RAM1, RAM2).
- The top level keeps decode, UART path and the ReadData mux.

Test Plan:
- Reset mid-RAM1 write (assert rst in WR2) → Ram1WE=1, Ram1EN=1, Ram1Data z and MemStall=0 within reset; memory unchanged.
- MemWrite at 16'h0010, data 16'hA5A5, then MemRead same address → stall 4 then 3 cycles, ReadData=16'hA5A5, WE low exactly 1 cycle.
- MemRead at 16'h9000 with RAM2 model holding 16'h1234 → RAM1 strobes idle, ReadData=16'h1234 in DONE cycle.
- MemRead at BF01 with data_ready=1, tbre=1, tsre=0 → ReadData=16'h0002, 1 stall cycle, rdn/wrn never low.
- MemWrite at BF00 with data 16'h0041 → wrn low 1 cycle, Ram1Data=16'h0041 while wrn low, Ram1EN=1 throughout.
- MemRead at BF00 with UART model returning 16'h005A → rdn low 1 cycle, ReadData=16'h005A; a BF02 read then returns 0.
